// File: rtl/link_sync_scheduler_pkg.sv
// link_sync_scheduler_pkg: shared types, register map and counter helpers for link_sync_scheduler
package link_sync_scheduler_pkg;
  localparam int CNT_W = 16;
  localparam int REG_CTRL = 0;
  localparam int REG_MASK = 1;
  localparam int REG_TIMING = 2;
  localparam int REG_STATUS = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DELAY = 2'd2, PLAY = 2'd3} state_e;
  typedef struct packed {
    logic [31:0] status;
    logic [31:0] timing;
    logic [31:0] link_mask;
    logic [31:0] ctrl;
  } param_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/link_sync_scheduler_param_decode.sv
// link_sync_scheduler_param_decode: IPIF register bank; word i is selected by chip-enable bit i
module link_sync_scheduler_param_decode #(
  parameter type PARAM_T = logic [127:0],
  parameter int N_REG = 4,
  parameter PARAM_T DEFAULTS = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_REG-1:0] rd_ce,
  input  logic [N_REG-1:0] wr_ce,
  input  logic [31:0]      wr_data,
  input  PARAM_T           rd_words,
  output PARAM_T           regs,
  output logic [31:0]      rd_data,
  output logic             wr_ack,
  output logic             rd_ack
);
  logic [N_REG*32-1:0] q, rd_v;
  assign regs = q;
  assign rd_v = rd_words;
  assign wr_ack = |wr_ce;
  assign rd_ack = |rd_ce;
  always_ff @(posedge clk) begin
    if (!resetn) q <= DEFAULTS;
    else for (int i = 0; i < N_REG; i++) if (wr_ce[i]) q[i*32 +: 32] <= wr_data;
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_REG; i++) if (rd_ce[i]) rd_data = rd_data | rd_v[i*32 +: 32];
  end
endmodule

// File: rtl/link_sync_scheduler.sv
// link_sync_scheduler: arms on ctrl.arm, aligns to orbit sync, restarts masked links and plays for N orbits.
// Optional macro LINK_SYNC_SCHED_TIMESTAMP_EN latches an orbit timestamp into status[15:3] at PLAY entry.
module link_sync_scheduler #(
  parameter int N_LINKS = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_REG = 4
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               IPIF_Bus2IP_resetn,
  input  logic [N_REG-1:0]   IPIF_Bus2IP_RdCE,
  input  logic [N_REG-1:0]   IPIF_Bus2IP_WrCE,
  input  logic [31:0]        IPIF_Bus2IP_Data,
  output logic [31:0]        IPIF_IP2Bus_Data,
  output logic               IPIF_IP2Bus_WrAck,
  output logic               IPIF_IP2Bus_RdAck,
  output logic               IPIF_IP2Bus_Error,
  input  logic               fc_orbitSync,
  input  logic [N_LINKS-1:0] link_ready,
  output logic [N_LINKS-1:0] link_sync,
  output logic [N_LINKS-1:0] link_enable,
  output logic               busy
);
  import link_sync_scheduler_pkg::*;
  localparam param_t REG_DEFAULTS = '{status: 32'h0, timing: 32'h0, link_mask: 32'hFFFF_FFFF, ctrl: 32'h0};
  param_t params, rd_words;
  logic [$bits(param_t)-1:0] regs_v, rd_v;
  state_e state, state_n;
  logic os_q, arm_q, late_q, late_n, arm, abort, cont, arm_edge, ready_ok;
  logic [N_LINKS-1:0] mask_w, mask_q, mask_n, sync_q, sync_n;
  logic [CNT_W-1:0] delay_orbits, play_orbits, delay_cnt, delay_n, done_cnt, done_n, dinc, pinc;
  logic [12:0] ts_field;
  logic [31:0] status_w;
  link_sync_scheduler_param_decode #(.PARAM_T(param_t), .N_REG(N_REG), .DEFAULTS(REG_DEFAULTS)) ipif_parameter_decode (
    .clk(clk), .resetn(IPIF_Bus2IP_resetn), .rd_ce(IPIF_Bus2IP_RdCE), .wr_ce(IPIF_Bus2IP_WrCE),
    .wr_data(IPIF_Bus2IP_Data), .rd_words(rd_words), .regs(params), .rd_data(IPIF_IP2Bus_Data),
    .wr_ack(IPIF_IP2Bus_WrAck), .rd_ack(IPIF_IP2Bus_RdAck)
  );
  assign regs_v = params;
  assign arm = regs_v[REG_CTRL*32];
  assign abort = regs_v[REG_CTRL*32+1];
  assign cont = regs_v[REG_CTRL*32+2];
  assign mask_w = regs_v[REG_MASK*32 +: N_LINKS];
  assign delay_orbits = regs_v[REG_TIMING*32 +: CNT_W];
  assign play_orbits = regs_v[REG_TIMING*32+16 +: CNT_W];
  assign status_w = {done_cnt, ts_field, late_q, state};
  always_comb begin
    rd_v = regs_v;
    rd_v[REG_CTRL*32 +: 32] = 32'(regs_v[REG_CTRL*32 +: 3]);
    rd_v[REG_MASK*32 +: 32] = 32'(mask_w);
    rd_v[REG_STATUS*32 +: 32] = status_w;
  end
  assign rd_words = rd_v;
  assign IPIF_IP2Bus_Error = 1'b0;
  assign arm_edge = arm & ~arm_q;
  assign ready_ok = &(link_ready | ~mask_w);
  assign dinc = sat_inc(delay_cnt);
  assign pinc = sat_inc(done_cnt);
  always_comb begin
    state_n = state;
    mask_n = mask_q;
    sync_n = '0;
    delay_n = delay_cnt;
    done_n = done_cnt;
    late_n = late_q & ~arm_edge;
    if (abort) state_n = IDLE;
    else case (state)
      IDLE: if (arm_edge) state_n = ARMED;
      ARMED: if (os_q) begin
        if (ready_ok) begin
          mask_n = mask_w;
          delay_n = '0;
          state_n = (delay_orbits == '0) ? PLAY : DELAY;
          sync_n = (delay_orbits == '0) ? mask_w : '0;
          done_n = '0;
        end else late_n = 1'b1;
      end
      DELAY: if (os_q) begin
        delay_n = dinc;
        state_n = (dinc == delay_orbits) ? PLAY : DELAY;
        sync_n = (dinc == delay_orbits) ? mask_q : '0;
        done_n = '0;
      end
      PLAY: if (os_q) begin
        // continuous mode shows the full count for one orbit before wrapping to 0
        done_n = (cont && play_orbits != '0 && done_cnt == play_orbits) ? '0 : pinc;
        state_n = (!cont && play_orbits != '0 && pinc == play_orbits) ? IDLE : PLAY;
        sync_n = (!cont && play_orbits != '0 && pinc == play_orbits) ? '0 : mask_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      os_q <= 1'b0;
      arm_q <= 1'b0;
      late_q <= 1'b0;
      mask_q <= '0;
      sync_q <= '0;
      delay_cnt <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_n;
      os_q <= fc_orbitSync;
      arm_q <= arm;
      late_q <= late_n;
      mask_q <= mask_n;
      sync_q <= sync_n;
      delay_cnt <= delay_n;
      done_cnt <= done_n;
    end
  end
`ifdef LINK_SYNC_SCHED_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cnt;
  logic [12:0] ts_q;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ts_cnt <= '0;
      ts_q <= '0;
    end else begin
      if (os_q) ts_cnt <= ts_cnt + CNT_W'(1);
      if (state_n == PLAY && state != PLAY) ts_q <= ts_cnt[12:0];
    end
  end
  assign ts_field = ts_q;
`else
  assign ts_field = '0;
`endif
  assign link_sync = sync_q;
  assign link_enable = (state == PLAY) ? mask_q : '0;
  assign busy = state != IDLE;
endmodule
